// File: rtl/cd_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cd_rx_frame
// Brief    : Receive frame parser - address filter, length check, CRC16 check,
//            header/payload writes into the receive RAM and commit strobe.
// Revision : 1.0 - initial release
// ============================================================================
module cd_rx_frame #(
    parameter int         MAX_LEN    = 253,
    parameter logic [7:0] BCAST_ADDR = 8'hff
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    input  logic       rx_idle,
    input  logic       rx_error,
    input  logic [7:0] filter,
    input  logic       promisc,
    input  logic       switch_fail,
    output logic [7:0] wr_byte,
    output logic [7:0] wr_addr,
    output logic       wr_en,
    output logic       switch,
    output logic [7:0] wr_flags,
    output logic       rx_ok,
    output logic       rx_crc_err,
    output logic       rx_drop,
    output logic       rx_abort,
    output logic       rx_lost
);

    localparam logic [7:0]  c_MAX_LEN  = 8'(MAX_LEN);
    localparam logic [15:0] c_CRC_INIT = 16'hffff;
    localparam logic [15:0] c_CRC_POLY = 16'ha001;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR       = 3'd1,
        S_DATA      = 3'd2,
        S_CRC       = 3'd3,
        S_CHK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t      r_state, w_state;
    logic [8:0]  r_cnt, w_cnt;
    logic [15:0] r_crc, w_crc;
    logic [7:0]  r_src, w_src;
    logic [7:0]  r_dst, w_dst;
    logic [7:0]  r_len, w_len;
    logic        r_pend, w_pend;
    logic        r_lost;
    logic        w_accept;
    logic [7:0]  w_wr_byte, w_wr_addr, w_wr_flags;
    logic        w_wr_en, w_switch, w_ok, w_crc_err, w_drop, w_abort;

    assign w_accept = promisc || (rx_byte == filter) || (rx_byte == BCAST_ADDR);
    assign rx_lost  = r_lost;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_crc      <= c_CRC_INIT;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_pend     <= 1'b0;
            r_lost     <= 1'b0;
            wr_byte    <= '0;
            wr_addr    <= '0;
            wr_en      <= 1'b0;
            wr_flags   <= '0;
            switch     <= 1'b0;
            rx_ok      <= 1'b0;
            rx_crc_err <= 1'b0;
            rx_drop    <= 1'b0;
            rx_abort   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_crc      <= w_crc;
            r_src      <= w_src;
            r_dst      <= w_dst;
            r_len      <= w_len;
            r_pend     <= w_pend;
            r_lost     <= switch_fail;
            wr_byte    <= w_wr_byte;
            wr_addr    <= w_wr_addr;
            wr_en      <= w_wr_en;
            wr_flags   <= w_wr_flags;
            switch     <= w_switch;
            rx_ok      <= w_ok;
            rx_crc_err <= w_crc_err;
            rx_drop    <= w_drop;
            rx_abort   <= w_abort;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_crc      = r_crc;
        w_src      = r_src;
        w_dst      = r_dst;
        w_len      = r_len;
        w_pend     = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_addr  = wr_addr;
        w_wr_byte  = wr_byte;
        w_wr_flags = wr_flags;
        w_switch   = 1'b0;
        w_ok       = 1'b0;
        w_crc_err  = 1'b0;
        w_drop     = 1'b0;
        w_abort    = 1'b0;

        // dst is written one cycle behind src; byte spacing keeps this slot free
        if (r_pend) begin
            w_wr_en   = 1'b1;
            w_wr_addr = 8'd1;
            w_wr_byte = r_dst;
        end

        case (r_state)
            S_IDLE: begin
                if (rx_byte_valid) begin
                    w_src   = rx_byte;
                    w_cnt   = 9'd1;
                    w_crc   = crc16_byte(c_CRC_INIT, rx_byte);
                    w_state = S_HDR;
                end
            end
            S_HDR, S_DATA, S_CRC: begin
                if (rx_error || rx_idle) begin
                    w_abort = 1'b1;
                    w_state = rx_error ? S_WAIT_IDLE : S_IDLE;
                end else if (rx_byte_valid) begin
                    w_crc = crc16_byte(r_crc, rx_byte);
                    w_cnt = r_cnt + 9'd1;
                    if (r_state == S_HDR && r_cnt == 9'd1) begin
                        if (w_accept) begin
                            w_wr_en   = 1'b1;
                            w_wr_addr = 8'd0;
                            w_wr_byte = r_src;
                            w_dst     = rx_byte;
                            w_pend    = 1'b1;
                        end else begin
                            w_drop  = 1'b1;
                            w_state = S_WAIT_IDLE;
                        end
                    end else if (r_state == S_HDR) begin
                        if (rx_byte > c_MAX_LEN) begin
                            w_abort = 1'b1;
                            w_state = S_WAIT_IDLE;
                        end else begin
                            w_wr_en    = 1'b1;
                            w_wr_addr  = 8'd2;
                            w_wr_byte  = rx_byte;
                            w_wr_flags = rx_byte;
                            w_len      = rx_byte;
                            w_state    = (rx_byte == 8'd0) ? S_CRC : S_DATA;
                        end
                    end else if (r_state == S_DATA) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_cnt[7:0];
                        w_wr_byte = rx_byte;
                        if (r_cnt == {1'b0, r_len} + 9'd2) begin
                            w_state = S_CRC;
                        end
                    end else if (r_cnt == {1'b0, r_len} + 9'd4) begin
                        w_state = S_CHK;
                    end
                end
            end
            S_CHK: begin
                // CRC over the whole frame including crc_l/crc_h leaves zero residue
                if (r_crc == 16'h0000) begin
                    w_switch = 1'b1;
                    w_ok     = 1'b1;
                end else begin
                    w_crc_err = 1'b1;
                end
                w_state = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rx_idle) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
